chain_latency_probe: RTL and testbench
======================================

Name: chain_latency_probe

Overview:
- Stimulus/measurement end of the register-chain delay line: drives the chain input, watches the chain output, reports measured latency in clk cycles.
- Sequence: flush the chain with zeros, launch a PULSE_W-cycle high pulse, count cycles until it emerges, verify the emerged pulse width.
- Sits beside the delay chain in the same clk domain; its results feed LEDs/readout logic.

Parameters:
- CNT_W, 20, width of latency and all internal counters.
- FLUSH_CYCLES, 65536, zero-drive cycles before launch; must exceed chain depth; < 2^CNT_W.
- PULSE_W, 4, launched pulse width in cycles; >= 1; < 2^CNT_W.
- TIMEOUT, 65535, maximum measure-wait count before abort; < 2^CNT_W - 1.

Ports:
- clk  input  1  system clock; everything is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; accepted only in IDLE or DONE.
- chain_in  output  1  registered drive into the delay chain input.
- chain_out  input  1  delay chain output; same clk domain, no synchronizer.
- busy  output  1  high in FLUSH, LAUNCH, MEASURE and WIDTH.
- done  output  1  high in DONE; held until the next accepted start.
- latency  output  CNT_W  measured latency; held while in DONE.
- timeout_err  output  1  pulse never seen within TIMEOUT; held in DONE.
- glitch_err  output  1  output high during final flush cycle, or wrong emerged width; held in DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE; chain_in=0, busy=0, done=0, latency=0, timeout_err=0, glitch_err=0, all counters 0. Reset mid-run aborts immediately with no partial result.
- IDLE/DONE: start=1 -> FLUSH. Clear done, errors, latency and counters on that edge. start while busy is ignored.
- FLUSH:
  - chain_in=0; count FLUSH_CYCLES cycles.
  - Sample chain_out on the last flush cycle; if 1, set glitch_err. Continue regardless.
  - -> LAUNCH.
- LAUNCH:
  - chain_in=1 for exactly PULSE_W cycles. Call E0 the edge at which chain_in first becomes 1.
  - Measurement counter runs from E0, counting edges after E0.
  - If chain_out is sampled 1 during LAUNCH, latency resolves there; the state still finishes the pulse first.
- MEASURE:
  - chain_in=0. Latency = n-1, where edge E0+n is the first edge sampling chain_out=1.
  - Result: direct wire loopback = 0; one register = 1; L registers = L.
  - If the count reaches TIMEOUT with no high sample, set timeout_err, set latency=all ones -> DONE.
- WIDTH:
  - Count consecutive high samples of chain_out starting with the first one.
  - At the first low sample, if count != PULSE_W set glitch_err -> DONE.
  - If count exceeds PULSE_W+TIMEOUT, set glitch_err -> DONE.
- DONE: busy=0, done=1; outputs stable until the next start.
- Counters saturate and never wrap.
- Latency tracking runs in both LAUNCH and MEASURE, so latency < PULSE_W is measured correctly.

Test Plan:
- chain_out wired to chain_in, PULSE_W=4, start pulse -> done=1, latency=0, timeout_err=0, glitch_err=0.
- chain_out through 1 flop, then through a 256-flop chain (FLUSH_CYCLES=300) -> latency=1, then latency=256; no errors.
- chain_out tied 0, TIMEOUT=100 -> after flush+launch+100 cycles, done=1, timeout_err=1, latency=all ones.
- 10-flop chain, chain_out stretched to 6 high cycles (PULSE_W=4) -> latency=10, glitch_err=1; chain_out forced 1 during flush -> glitch_err=1.
- rst_n low mid-MEASURE -> chain_in=0, busy=0, done=0, latency=0 immediately; after release, new start measures correctly. start toggled while busy -> no restart, latency unchanged.

Source files
------------

// File: rtl/chain_latency_probe.sv
// Measurement end of a register-chain delay line: flushes the chain, launches a
// PULSE_W-cycle pulse, counts clk cycles until it emerges and checks its width.
module chain_latency_probe #(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned FLUSH_CYCLES = 65536,
  parameter int unsigned PULSE_W      = 4,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] latency,
  output logic             timeout_err,
  output logic             glitch_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LAUNCH, S_MEASURE, S_WIDTH, S_DONE
  } state_t;

  localparam int unsigned      CNT_W1     = CNT_W + 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PW         = CNT_W'(PULSE_W);
  localparam logic [CNT_W:0]   WIDTH_MAX  = CNT_W1'(PULSE_W + TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;       // flush / pulse phase counter
  logic [CNT_W-1:0] mcnt;      // edges after launch, minus one
  logic [CNT_W-1:0] wcnt;      // consecutive high samples of chain_out
  logic             resolved;  // first high sample already seen
  logic             wfin;      // pulse ended while still launching

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      chain_in    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      latency     <= '0;
      timeout_err <= 1'b0;
      glitch_err  <= 1'b0;
      cnt         <= '0;
      mcnt        <= '0;
      wcnt        <= '0;
      resolved    <= 1'b0;
      wfin        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_FLUSH;
            chain_in    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            latency     <= '0;
            timeout_err <= 1'b0;
            glitch_err  <= 1'b0;
            cnt         <= '0;
            mcnt        <= '0;
            wcnt        <= '0;
            resolved    <= 1'b0;
            wfin        <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            if (chain_out) glitch_err <= 1'b1;
            state    <= S_LAUNCH;
            chain_in <= 1'b1;
            cnt      <= '0;
            mcnt     <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_LAUNCH: begin
          // Latency and width tracking already run here so short chains resolve
          // before the launched pulse has finished.
          if (!resolved) begin
            if (chain_out) begin
              resolved <= 1'b1;
              latency  <= mcnt;
              wcnt     <= CNT_W'(1);
            end else begin
              mcnt <= sat_inc(mcnt);
            end
          end else if (!wfin) begin
            if (chain_out) begin
              wcnt <= sat_inc(wcnt);
            end else begin
              wfin <= 1'b1;
              if (wcnt != PW) glitch_err <= 1'b1;
            end
          end
          if (cnt == PULSE_LAST) begin
            chain_in <= 1'b0;
            if (wfin || (resolved && !chain_out)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (resolved || chain_out) begin
              state <= S_WIDTH;
            end else begin
              state <= S_MEASURE;
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_MEASURE: begin
          if (chain_out) begin
            resolved <= 1'b1;
            latency  <= mcnt;
            wcnt     <= CNT_W'(1);
            state    <= S_WIDTH;
          end else if (mcnt >= TO_LAST) begin
            timeout_err <= 1'b1;
            latency     <= '1;
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            mcnt <= sat_inc(mcnt);
          end
        end
        S_WIDTH: begin
          if (chain_out) begin
            if (({1'b0, wcnt} >= WIDTH_MAX) || (&wcnt)) begin
              glitch_err <= 1'b1;
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              wcnt <= sat_inc(wcnt);
            end
          end else begin
            if (wcnt != PW) glitch_err <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chain_latency_probe.sv
// Bench for chain_latency_probe: a behavioural delay chain on chain_in/chain_out,
// expected results queued at launch and compared when done rises.
module tb_chain_latency_probe;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned FLUSH    = 300;
  localparam int unsigned PW       = 4;
  localparam int unsigned TO_MAIN  = 400;
  localparam int unsigned TO_SHORT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_to = 1'b0;
  logic chain_in, chain_out, busy, done, timeout_err, glitch_err;
  logic [CNT_W-1:0] latency;
  logic chain_in_t, busy_t, done_t, to_t, gl_t;
  logic [CNT_W-1:0] lat_t;

  logic [299:0] sr = '0;
  int unsigned  mode = 0;
  int unsigned  len = 1;
  logic         force_hi = 1'b0;
  int unsigned  cyc = 0;
  int           nvec = 0;
  int           nerr = 0;

  typedef struct packed {
    logic [CNT_W-1:0] lat;
    logic             to;
    logic             gl;
  } exp_t;
  exp_t sb[$];

  chain_latency_probe #(
    .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH), .PULSE_W(PW), .TIMEOUT(TO_MAIN)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chain_in(chain_in),
    .chain_out(chain_out), .busy(busy), .done(done), .latency(latency),
    .timeout_err(timeout_err), .glitch_err(glitch_err)
  );

  chain_latency_probe #(
    .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH), .PULSE_W(PW), .TIMEOUT(TO_SHORT)
  ) u_to (
    .clk(clk), .rst_n(rst_n), .start(start_to), .chain_in(chain_in_t),
    .chain_out(1'b0), .busy(busy_t), .done(done_t), .latency(lat_t),
    .timeout_err(to_t), .glitch_err(gl_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sr  <= {sr[298:0], chain_in};
    cyc <= cyc + 1;
  end

  // 0: wire loopback, 1: len flops, 2: len flops stretched by two cycles,
  // 3: one flop with chain_out forced high until launch.
  always_comb begin
    case (mode)
      0:       chain_out = chain_in;
      1:       chain_out = sr[len-1];
      2:       chain_out = sr[len-1] | sr[len+1];
      default: chain_out = sr[0] | force_hi;
    endcase
  end

  function automatic exp_t mk(input int unsigned l, input logic t, input logic g);
    exp_t e;
    e.lat = CNT_W'(l);
    e.to  = t;
    e.gl  = g;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int unsigned maxc, input bit tog);
    int unsigned k = 0;
    while (!done && k < maxc) begin
      if (tog) start = ((k % 7) == 3);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input int unsigned m, input int unsigned l,
                     input exp_t e, input bit tog, output int unsigned elapsed);
    exp_t        got;
    int unsigned s;
    mode     = m;
    len      = l;
    force_hi = (m == 3);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_clr"}, 32'({done, timeout_err, glitch_err, latency}), 32'd0);
    if (m == 3) begin
      for (int i = 0; i < 1000 && !chain_in; i++) @(negedge clk);
      force_hi = 1'b0;
    end
    wait_done(tag, 2000, tog);
    elapsed = cyc - s;
    got = sb.pop_front();
    check({tag, "_lat"}, 32'(latency), 32'(got.lat));
    check({tag, "_to"}, 32'(timeout_err), 32'(got.to));
    check({tag, "_gl"}, 32'(glitch_err), 32'(got.gl));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned el;
    int unsigned s;
    int unsigned k;

    repeat (3) @(negedge clk);
    check("rst_chain_in", 32'(chain_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lat", 32'(latency), 32'd0);
    check("rst_errs", 32'({timeout_err, glitch_err}), 32'd0);
    rst_n = 1'b1;

    run("loop", 0, 1, mk(0, 1'b0, 1'b0), 1'b0, el);
    run("flop1", 1, 1, mk(1, 1'b0, 1'b0), 1'b0, el);
    run("flop256", 1, 256, mk(256, 1'b0, 1'b0), 1'b0, el);
    run("stretch", 2, 10, mk(10, 1'b0, 1'b1), 1'b0, el);
    run("flushhi", 3, 1, mk(1, 1'b0, 1'b1), 1'b0, el);

    // Chain output stuck low on the short-timeout instance.
    @(negedge clk);
    start_to = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start_to = 1'b0;
    k = 0;
    while (!done_t && k < 2000) begin
      @(negedge clk);
      k++;
    end
    el = cyc - s;
    check("to_done", 32'(done_t), 32'd1);
    check("to_flag", 32'(to_t), 32'd1);
    check("to_lat", 32'(lat_t), 32'hFFFF);
    check("to_gl", 32'(gl_t), 32'd0);
    check("to_time", 32'(el >= FLUSH + TO_SHORT && el <= FLUSH + PW + TO_SHORT + 1), 32'd1);

    // Reset while waiting for a 256-deep chain.
    mode = 1;
    len  = 256;
    sb.push_back(mk(256, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000 && !chain_in; i++) @(negedge clk);
    for (int i = 0; i < 100 && chain_in; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_chain_in", 32'(chain_in), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_lat", 32'(latency), 32'd0);
    check("abort_errs", 32'({timeout_err, glitch_err}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh measurement after reset, with start toggled while busy.
    run("restart", 1, 10, mk(10, 1'b0, 1'b0), 1'b1, el);
    check("restart_time", el, FLUSH + 10 + 1 + PW);
    repeat (5) @(negedge clk);
    check("hold_lat", 32'(latency), 32'd10);
    check("hold_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
